fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Drives the PC into the combinational instruction memory and sequences the IF stage.
//  Buffers fetched {pc,instr} pairs in a 2-entry queue behind a valid/ready handshake to IF/ID.
//  Handles redirects (branch/jump flush), halts on a terminator word or out-of-range fetch,
//  and reports misaligned redirect targets.
// PARAMETERS
//  RESET_PC    64'd0          PC loaded on reset
//  IMEM_BYTES  1024           instruction memory size in bytes; last legal fetch PC = IMEM_BYTES-4
//  HALT_WORD   32'h0000_0000  fetched word that terminates the program (not delivered to decode)
// PORTS
//  clk           in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-high
//  imem_pc       out  64  address to instruction memory (= internal pc register)
//  imem_instr    in   32  instruction word returned combinationally for imem_pc
//  if_valid      out  1   head entry of queue is valid
//  if_ready      in   1   decode accepts head entry this cycle
//  if_pc         out  64  PC of head entry
//  if_instr      out  32  instruction of head entry
//  redirect_valid in  1   flush and restart fetch at redirect_pc
//  redirect_pc   in   64  new fetch target
//  halted        out  1   sequencer in HALT state
//  misalign_err  out  1   sticky: redirect_pc[1:0] != 0 was taken
//  oob_err       out  1   sticky: pc exceeded IMEM_BYTES-4
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=IDLE, queue empty.
//   All outputs 0 except imem_pc=RESET_PC; errors cleared.
//  States: IDLE -> FETCH on first edge after reset release (no push in IDLE).
//   FETCH -> HALT on HALT_WORD, oob or misalign. HALT -> FETCH only on a legal redirect.
//  FETCH push: at an edge with space (count<2, or count==2 with a pop the same cycle),
//   push {pc,imem_instr} and set pc <= pc+4.
//   Result: first if_valid rises after the 2nd edge post-reset.
//  No space: pc holds (stall); imem_pc stable.
//  Pop: when if_valid & if_ready; head advances.
//   Push and pop in the same cycle keep count unchanged; order is preserved.
//  HALT_WORD fetched: not pushed; pc holds; state -> HALT; halted=1 next cycle.
//   Queued entries remain and still drain to decode.
//  Out of range: pc > IMEM_BYTES-4 in FETCH -> no push; oob_err=1; state -> HALT.
//  Redirect: has highest priority, in any state except IDLE.
//   That edge: queue flushed (count=0); any pop that cycle is discarded; no push.
//   pc <= redirect_pc; state -> FETCH.
//  Misaligned redirect: redirect_pc[1:0]!=0 -> flush, pc <= redirect_pc, misalign_err=1, state -> HALT.
//  Redirect in HALT: legal target resumes FETCH and clears halted. Error flags stay sticky until reset.
//  Redirect while reset is asserted: ignored.
//  Reset mid-operation: immediate return to reset values regardless of queue contents.
//  Arithmetic: pc+4 is 64-bit; wrap is not reachable because of the oob check. Overflow is ignored.
//  if_pc/if_instr are don't-care when if_valid=0; the bench must not check them then.
// STRUCTURE
//  Include file fetch_defs.vh: state localparams IDLE=2'd0, FETCH=2'd1, HALT=2'd2, and the INSTR_W/PC_W widths.
//  Sub-module fetch_fifo2: 2-entry {64b pc, 32b instr} queue with push/pop/flush, count[1:0], head outputs.
//  pc+4 uses a Cla64bit instance (B=64'd4), consistent with the datapath adders.
//  Top level holds the state FSM, pc register, error flags, and push/stall/redirect decode.
// TESTING
//  1 Memory bytes 0..11 = words W0,W1,W2, then 32'h0, with if_ready=1.
//     -> if_pc 0,4,8 delivered on consecutive cycles with if_instr = W0..W2.
//     -> halted=1; no 4th if_valid.
//  2 Backpressure: if_ready=0 for 5 cycles.
//     -> count saturates at 2 and imem_pc holds at 8.
//     -> on release, entries (0,W0),(4,W1) drain in order, then fetch resumes at 8.
//  3 Redirect to 64'h40 with 2 entries queued and if_ready=1 the same cycle.
//     -> queue flushed; next delivered if_pc=64'h40; no entry with pc 0/4 is delivered.
//  4 Redirect to 64'h42.
//     -> misalign_err=1, halted=1, if_valid=0 thereafter.
//     -> a later redirect to 64'h10 resumes fetch with if_pc=64'h10 while misalign_err stays 1.
//  5 Straight-line nonzero code to the end of memory (IMEM_BYTES=1024).
//     -> last if_pc=1020; then oob_err=1, halted=1.
//  6 Assert reset mid-stream with 2 entries queued.
//     -> same cycle: if_valid=0, imem_pc=RESET_PC.
//     -> after release: first if_valid at the 2nd edge with if_pc=0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_sequencer_pkg
// Brief   : Shared widths, FSM state encodings and helpers for the IF stage.
// Revision: 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

  localparam int c_PC_W    = 64;
  localparam int c_INSTR_W = 32;

  // Sequencer states (2-bit encoding kept stable for legacy tooling)
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FETCH = 2'd1;
  localparam logic [1:0] c_HALT  = 2'd2;

  // A fetch target is legal only when it sits on a 4-byte boundary
  function automatic logic is_word_aligned(input logic [1:0] i_lsbs);
    return (i_lsbs == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_cla64.sv
`default_nettype none
// ============================================================================
// Module  : Cla64bit
// Brief   : 64-bit adder built from 4-bit carry-lookahead groups.
//           Carry-out is not exported; pc wrap is prevented upstream.
// Revision: 1.0 - initial release
// ============================================================================
module Cla64bit
  import fetch_sequencer_pkg::*;
(
  input  logic [c_PC_W-1:0] i_a,
  input  logic [c_PC_W-1:0] i_b,
  input  logic              i_cin,
  output logic [c_PC_W-1:0] o_sum
);

  logic [c_PC_W-1:0] w_g;
  logic [c_PC_W-1:0] w_p;
  logic [c_PC_W-1:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Lookahead inside each 4-bit group; group carries chain between groups
  always_comb begin : p_carry
    logic w_grp_c;
    w_grp_c = i_cin;
    w_c     = '0;
    for (int k = 0; k < c_PC_W / 4; k++) begin
      w_c[4*k]   = w_grp_c;
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_grp_c);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_grp_c);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_grp_c);
      w_grp_c    = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_grp_c);
    end
  end

  assign o_sum = w_p ^ w_c;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer_fifo2.sv
`default_nettype none
// ============================================================================
// Module  : fetch_fifo2
// Brief   : Two-entry {pc, instr} queue with push, pop and flush.
//           Flush wins over push/pop in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_fifo2
  import fetch_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic                 i_flush,
  input  logic [c_PC_W-1:0]    i_pc,
  input  logic [c_INSTR_W-1:0] i_instr,
  output logic [1:0]           o_count,
  output logic                 o_valid,
  output logic [c_PC_W-1:0]    o_pc,
  output logic [c_INSTR_W-1:0] o_instr
);

  logic [c_PC_W-1:0]    r_pc    [2];
  logic [c_INSTR_W-1:0] r_instr [2];
  logic                 r_head;
  logic [1:0]           r_count;
  logic                 w_tail;
  logic                 w_do_pop;

  // Tail = head + count (mod 2); with count==2 this is the slot a pop frees
  assign w_tail   = r_head ^ r_count[0];
  assign w_do_pop = i_pop && (r_count != 2'd0);

  // Occupancy and head pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
    end else if (i_flush) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
    end else begin
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_do_pop};
      r_head  <= r_head ^ w_do_pop;
    end
  end

  // Entry storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_pc[w_tail]    <= i_pc;
      r_instr[w_tail] <= i_instr;
    end
  end

  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);
  assign o_pc    = r_pc[r_head];
  assign o_instr = r_instr[r_head];

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fetch_sequencer
// Brief   : Drives the PC into combinational instruction memory, queues
//           fetched {pc, instr} pairs for decode, handles redirects, halt
//           words, out-of-range fetches and misaligned redirect targets.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int          IMEM_BYTES = 1024,
  parameter logic [31:0] HALT_WORD  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [c_PC_W-1:0]    imem_pc,
  input  logic [c_INSTR_W-1:0] imem_instr,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [c_PC_W-1:0]    if_pc,
  output logic [c_INSTR_W-1:0] if_instr,
  input  logic                 redirect_valid,
  input  logic [c_PC_W-1:0]    redirect_pc,
  output logic                 halted,
  output logic                 misalign_err,
  output logic                 oob_err
);

  localparam logic [c_PC_W-1:0] c_LAST_PC = 64'(IMEM_BYTES - 4);

  logic [1:0]        r_state;
  logic [c_PC_W-1:0] r_pc;
  logic              r_misalign;
  logic              r_oob;

  logic [1:0]        w_count;
  logic [c_PC_W-1:0] w_pc_plus4;
  logic              w_pop;
  logic              w_space;
  logic              w_redirect;
  logic              w_fetching;
  logic              w_oob;
  logic              w_halt_word;
  logic              w_push;

  // Handshake and push/stall decode; a redirect suppresses fetch that cycle
  assign w_pop       = if_valid && if_ready;
  assign w_space     = (w_count != 2'd2) || w_pop;
  assign w_redirect  = redirect_valid && (r_state != c_IDLE);
  assign w_fetching  = (r_state == c_FETCH) && !w_redirect;
  assign w_oob       = (r_pc > c_LAST_PC);
  assign w_halt_word = (imem_instr == HALT_WORD);
  assign w_push      = w_fetching && !w_oob && !w_halt_word && w_space;

  Cla64bit u_pc_adder (
    .i_a   (r_pc),
    .i_b   (64'd4),
    .i_cin (1'b0),
    .o_sum (w_pc_plus4)
  );

  fetch_fifo2 u_queue (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_pc    (r_pc),
    .i_instr (imem_instr),
    .o_count (w_count),
    .o_valid (if_valid),
    .o_pc    (if_pc),
    .o_instr (if_instr)
  );

  // Sequencer FSM, pc register and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
      r_oob      <= 1'b0;
    end else if (w_redirect) begin
      r_pc <= redirect_pc;
      if (is_word_aligned(redirect_pc[1:0])) begin
        r_state <= c_FETCH;
      end else begin
        r_state    <= c_HALT;
        r_misalign <= 1'b1;
      end
    end else begin
      case (r_state)
        c_IDLE:  r_state <= c_FETCH;
        c_FETCH: begin
          if (w_oob) begin
            r_oob   <= 1'b1;
            r_state <= c_HALT;
          end else if (w_halt_word) begin
            r_state <= c_HALT;
          end else if (w_push) begin
            r_pc <= w_pc_plus4;
          end
        end
        c_HALT:  r_state <= c_HALT;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign imem_pc      = r_pc;
  assign halted       = (r_state == c_HALT);
  assign misalign_err = r_misalign;
  assign oob_err      = r_oob;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_sequencer
// Brief   : Directed self-checking bench for fetch_sequencer with a
//           combinational 1 KiB instruction memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [63:0] imem_pc;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halted;
  logic        misalign_err;
  logic        oob_err;

  logic [31:0] mem [256];
  int          n_checks;
  int          n_errors;

  fetch_sequencer #(
    .RESET_PC   (64'd0),
    .IMEM_BYTES (1024),
    .HALT_WORD  (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .misalign_err   (misalign_err),
    .oob_err        (oob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Out-of-range addresses return a nonzero junk word so only the oob check can stop fetch
  assign imem_instr = (imem_pc <= 64'd1020) ? mem[imem_pc[9:2]] : 32'hFFFF_FFFF;

  function automatic logic [31:0] word_at(input int idx);
    return 32'hA500_0000 | 32'(idx);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    for (int i = 0; i < 256; i++) mem[i] = word_at(i);

    // 1: three words then a halt word, decode always ready
    mem[3] = 32'h0;
    step();
    step();
    check("rst_valid",    64'(if_valid),     64'd0);
    check("rst_halted",   64'(halted),       64'd0);
    check("rst_imem_pc",  imem_pc,           64'd0);
    check("rst_misalign", 64'(misalign_err), 64'd0);
    check("rst_oob",      64'(oob_err),      64'd0);
    reset = 1'b0;
    step();
    check("t1_idle_valid", 64'(if_valid), 64'd0);
    check("t1_idle_pc",    imem_pc,       64'd0);
    step();
    check("t1_valid0", 64'(if_valid), 64'd1);
    check("t1_pc0",    if_pc,         64'd0);
    check("t1_ins0",   64'(if_instr), 64'(word_at(0)));
    step();
    check("t1_pc1",  if_pc,         64'd4);
    check("t1_ins1", 64'(if_instr), 64'(word_at(1)));
    step();
    check("t1_pc2",  if_pc,         64'd8);
    check("t1_ins2", 64'(if_instr), 64'(word_at(2)));
    step();
    check("t1_halted",   64'(halted),   64'd1);
    check("t1_no_4th",   64'(if_valid), 64'd0);
    step();
    check("t1_still_no", 64'(if_valid), 64'd0);
    mem[3] = word_at(3);

    // 2: backpressure for five edges, then drain in order
    if_ready = 1'b0;
    do_reset();
    step();
    step();
    step();
    check("t2_full_pc", imem_pc, 64'd8);
    step();
    step();
    check("t2_stall_pc",   imem_pc,       64'd8);
    check("t2_head_valid", 64'(if_valid), 64'd1);
    check("t2_head_pc",    if_pc,         64'd0);
    check("t2_head_ins",   64'(if_instr), 64'(word_at(0)));
    if_ready = 1'b1;
    step();
    check("t2_drain_pc1", if_pc,   64'd4);
    check("t2_resume",    imem_pc, 64'd12);
    step();
    check("t2_drain_pc2", if_pc,         64'd8);
    check("t2_drain_ins", 64'(if_instr), 64'(word_at(2)));
    step();
    check("t2_drain_pc3", if_pc, 64'd12);

    // 3: redirect with two entries queued and a pop offered the same edge
    if_ready = 1'b0;
    do_reset();
    step();
    step();
    step();
    check("t3_pre_pc", if_pc, 64'd0);
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    step();
    redirect_valid = 1'b0;
    check("t3_flushed", 64'(if_valid), 64'd0);
    check("t3_imem_pc", imem_pc,       64'h40);
    step();
    check("t3_valid",  64'(if_valid), 64'd1);
    check("t3_pc40",   if_pc,         64'h40);
    check("t3_ins40",  64'(if_instr), 64'(word_at(16)));
    step();
    check("t3_pc44",   if_pc,         64'h44);

    // 4: misaligned redirect halts; a later legal redirect resumes
    redirect_valid = 1'b1;
    redirect_pc    = 64'h42;
    step();
    redirect_valid = 1'b0;
    check("t4_misalign", 64'(misalign_err), 64'd1);
    check("t4_halted",   64'(halted),       64'd1);
    check("t4_novalid",  64'(if_valid),     64'd0);
    step();
    step();
    check("t4_still_novalid", 64'(if_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h10;
    step();
    redirect_valid = 1'b0;
    check("t4_unhalted", 64'(halted), 64'd0);
    step();
    check("t4_valid",  64'(if_valid),     64'd1);
    check("t4_pc10",   if_pc,             64'h10);
    check("t4_ins10",  64'(if_instr),     64'(word_at(4)));
    check("t4_sticky", 64'(misalign_err), 64'd1);

    // 5: run to the end of memory
    redirect_valid = 1'b1;
    redirect_pc    = 64'd1008;
    step();
    redirect_valid = 1'b0;
    check("t5_no_oob_yet", 64'(oob_err), 64'd0);
    step();
    check("t5_pc1008", if_pc, 64'd1008);
    step();
    check("t5_pc1012", if_pc, 64'd1012);
    step();
    check("t5_pc1016", if_pc, 64'd1016);
    step();
    check("t5_pc1020",  if_pc,         64'd1020);
    check("t5_ins1020", 64'(if_instr), 64'(word_at(255)));
    step();
    check("t5_oob",     64'(oob_err),  64'd1);
    check("t5_halted",  64'(halted),   64'd1);
    check("t5_novalid", 64'(if_valid), 64'd0);

    // 6: asynchronous reset mid-stream with two entries queued
    if_ready = 1'b0;
    do_reset();
    step();
    step();
    step();
    check("t6_pre_valid", 64'(if_valid), 64'd1);
    check("t6_pre_pc",    imem_pc,       64'd8);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", 64'(if_valid), 64'd0);
    check("t6_async_pc",    imem_pc,       64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h80;
    step();
    check("t6_redir_ignored", imem_pc, 64'd0);
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    reset          = 1'b0;
    step();
    check("t6_idle_valid", 64'(if_valid), 64'd0);
    step();
    check("t6_valid", 64'(if_valid), 64'd1);
    check("t6_pc0",   if_pc,         64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
